instruction_fetch_unit: RTL

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

---
 rtl/ifu_pkg.sv | 11 +
 rtl/fetch_skid_buffer.sv | 34 +++
 rtl/instruction_fetch_unit.sv | 127 ++++++++++++
 3 files changed

// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;
  localparam int PC_W = 32;
  localparam logic [PC_W-1:0] NOP = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HOLD
  } ifu_state_e;
endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry skid buffer that parks a fetched instruction while downstream stalls.
module fetch_skid_buffer
  import ifu_pkg::*;
(
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            load,
  input  logic            drain,
  input  logic            flush,
  input  logic [PC_W-1:0] load_instr,
  input  logic [PC_W-1:0] load_pc,
  output logic            valid,
  output logic [PC_W-1:0] instr,
  output logic [PC_W-1:0] pc
);

  // Flush wins so a redirect always discards the parked entry.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      valid <= 1'b0;
      instr <= NOP;
      pc    <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      instr <= load_instr;
      pc    <= load_pc;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: one request per cycle, skid on stall, redirect kills in-flight work.
// Define IFU_PERF_CNT_EN to add the FetchCount/KillCount performance counters.
module instruction_fetch_unit
  import ifu_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            CLK,
  input  logic            RST_N,
  output logic [PC_W-1:0] Address,
  input  logic [PC_W-1:0] Instr,
  input  logic            Redirect,
  input  logic [PC_W-1:0] RedirectPC,
  input  logic            IF_Ready,
  output logic            IF_Valid,
  output logic [PC_W-1:0] IF_Instr,
  output logic [PC_W-1:0] IF_PC
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]     FetchCount,
  output logic [31:0]     KillCount
`endif
);

  ifu_state_e      state_q;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] inflight_pc_q;
  logic            inflight_q;

  logic            skid_load;
  logic            skid_drain;
  logic            skid_valid;
  logic [PC_W-1:0] skid_instr;
  logic [PC_W-1:0] skid_pc;
  logic            unused_redirect_lsbs;

  assign Address              = {2'b00, pc_q[PC_W-1:2]};
  assign unused_redirect_lsbs = ^RedirectPC[1:0];

  assign skid_load  = (state_q == RUN) && inflight_q && !IF_Ready && !Redirect;
  assign skid_drain = (state_q == HOLD) && IF_Ready && !Redirect;

  fetch_skid_buffer u_skid (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .load       (skid_load),
    .drain      (skid_drain),
    .flush      (Redirect),
    .load_instr (Instr),
    .load_pc    (inflight_pc_q),
    .valid      (skid_valid),
    .instr      (skid_instr),
    .pc         (skid_pc)
  );

  // Parked entry takes precedence; otherwise memory data passes straight through.
  always_comb begin
    IF_Valid = 1'b0;
    IF_Instr = NOP;
    IF_PC    = '0;
    if (skid_valid) begin
      IF_Valid = 1'b1;
      IF_Instr = skid_instr;
      IF_PC    = skid_pc;
    end else if (inflight_q) begin
      IF_Valid = 1'b1;
      IF_Instr = Instr;
      IF_PC    = inflight_pc_q;
    end
  end

  // The BOOT cycle already presents RESET_PC, so leaving BOOT counts it as issued.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else if (Redirect) begin
      state_q    <= RUN;
      pc_q       <= {RedirectPC[PC_W-1:2], 2'b00};
      inflight_q <= 1'b0;
    end else begin
      unique case (state_q)
        BOOT: begin
          state_q       <= RUN;
          pc_q          <= pc_q + 32'd4;
          inflight_q    <= 1'b1;
          inflight_pc_q <= pc_q;
        end
        RUN: begin
          if (inflight_q && !IF_Ready) begin
            state_q    <= HOLD;
            inflight_q <= 1'b0;
          end else begin
            pc_q          <= pc_q + 32'd4;
            inflight_q    <= 1'b1;
            inflight_pc_q <= pc_q;
          end
        end
        HOLD: begin
          if (IF_Ready) begin
            state_q       <= RUN;
            pc_q          <= pc_q + 32'd4;
            inflight_q    <= 1'b1;
            inflight_pc_q <= pc_q;
          end
        end
        default: state_q <= BOOT;
      endcase
    end
  end

`ifdef IFU_PERF_CNT_EN
  // A kill is a redirect that discards an instruction downstream did not take.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      FetchCount <= '0;
      KillCount  <= '0;
    end else begin
      if (IF_Valid && IF_Ready) FetchCount <= FetchCount + 32'd1;
      if (Redirect && IF_Valid && !IF_Ready) KillCount <= KillCount + 32'd1;
    end
  end
`endif

endmodule
